// File: rtl/frog_game_fsm_pkg.sv
// Shared types and helpers for the Frogger game-state controller.
// State codes are also consumed by the HUD/VGA overlay.
package frog_game_fsm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_DEAD    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_WIN     = 3'd4,
        ST_OVER    = 3'd5
    } game_state_e;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int bits_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frog_game_fsm_sec_tick_gen.sv
// One-second tick generator: free-running divider with a synchronous clear.
// tick_o pulses for one cycle every DIV cycles; the first tick after a clear takes a full DIV.
module sec_tick_gen #(
    parameter int DIV = 100000000
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Divider counter: wraps on the last count, restarts from zero on clear.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            cnt_q <= '0;
        end else if (clear_i || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/frog_game_fsm.sv
// Frogger game-state controller: level, lives and per-life countdown,
// with movement enable, respawn pulse and win/lose flags for the HUD.
module frog_game_fsm
    import frog_game_fsm_pkg::*;
#(
    parameter int NUM_LEVELS    = 5,
    parameter int START_LIVES   = 3,
    parameter int TIME_LIMIT    = 30,
    parameter int TICK_DIV      = 100000000,
    parameter int RESPAWN_TICKS = 1,
    parameter int Y_W           = 9,
    parameter int GOAL_Y        = 90,
    parameter int LEVEL_W       = bits_for(NUM_LEVELS),
    parameter int LIVES_W       = bits_for(START_LIVES + 1),
    parameter int TIME_W        = bits_for(TIME_LIMIT + 1)
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               start_i,
    input  logic               collision_i,
    input  logic [Y_W-1:0]     frog_y_i,
    output logic               play_en_o,
    output logic               respawn_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic [LIVES_W-1:0] lives_o,
    output logic [TIME_W-1:0]  time_left_o,
    output logic [STATE_W-1:0] state_o,
    output logic               gameover_o,
    output logic               gamewin_o
);

    localparam int RESP_W = bits_for(RESPAWN_TICKS);

    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0] ONE_LIFE   = LIVES_W'(1);
    localparam logic [TIME_W-1:0]  FULL_TIME  = TIME_W'(TIME_LIMIT);
    localparam logic [TIME_W-1:0]  ONE_SEC    = TIME_W'(1);
    localparam logic [Y_W-1:0]     GOAL_ROW   = Y_W'(GOAL_Y);
    localparam logic [RESP_W-1:0]  RESP_LAST  = RESP_W'(RESPAWN_TICKS - 1);

    game_state_e         state_q;
    game_state_e         state_d;
    logic [LEVEL_W-1:0]  level_q;
    logic [LIVES_W-1:0]  lives_q;
    logic [TIME_W-1:0]   time_q;
    logic [RESP_W-1:0]   resp_cnt_q;
    logic                hit_mask_q;
    logic                respawn_q;

    logic                tick;
    logic                clear_div;
    logic                enter_play;
    logic                hit;
    logic                timeout;
    logic                death;
    logic                goal;
    logic                restart;

    sec_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clear_i  (clear_div),
        .tick_o   (tick)
    );

    // Event decode; a held collision only counts again after it drops.
    always_comb begin
        hit        = collision_i && !hit_mask_q;
        timeout    = tick && (time_q <= ONE_SEC);
        death      = hit || timeout;
        goal       = (frog_y_i <= GOAL_ROW);
        restart    = start_i && ((state_q == ST_IDLE) ||
                                 (state_q == ST_WIN)  ||
                                 (state_q == ST_OVER));
        enter_play = (state_d == ST_PLAY) && (state_q != ST_PLAY);
        clear_div  = (state_d != state_q);
    end

    // State register.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; death outranks reaching the goal row.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (death) begin
                    state_d = (lives_q <= ONE_LIFE) ? ST_OVER : ST_DEAD;
                end else if (goal) begin
                    state_d = (level_q == LAST_LEVEL) ? ST_WIN : ST_ADVANCE;
                end
            end
            ST_DEAD: begin
                if (tick && (resp_cnt_q == RESP_LAST)) state_d = ST_PLAY;
            end
            ST_ADVANCE: begin
                state_d = ST_PLAY;
            end
            ST_WIN, ST_OVER: begin
                if (start_i) state_d = ST_PLAY;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Level and lives bookkeeping, saturating in both directions.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            level_q <= '0;
            lives_q <= FULL_LIVES;
        end else if (restart) begin
            level_q <= '0;
            lives_q <= FULL_LIVES;
        end else if (state_q == ST_ADVANCE) begin
            if (level_q != LAST_LEVEL) level_q <= level_q + 1'b1;
            lives_q <= FULL_LIVES;
        end else if ((state_q == ST_PLAY) && death) begin
            if (lives_q != '0) lives_q <= lives_q - 1'b1;
        end
    end

    // Per-life countdown: reloaded on every entry to PLAY, stops at zero.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            time_q <= FULL_TIME;
        end else if (enter_play) begin
            time_q <= FULL_TIME;
        end else if ((state_q == ST_PLAY) && tick && (time_q != '0)) begin
            time_q <= time_q - 1'b1;
        end
    end

    // Ticks spent in DEAD before the frog respawns.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            resp_cnt_q <= '0;
        end else if (state_q != ST_DEAD) begin
            resp_cnt_q <= '0;
        end else if (tick && (resp_cnt_q != RESP_LAST)) begin
            resp_cnt_q <= resp_cnt_q + 1'b1;
        end
    end

    // Respawn pulse on PLAY entry and collision masking until release.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            respawn_q  <= 1'b0;
            hit_mask_q <= 1'b0;
        end else begin
            respawn_q <= enter_play;
            if (!collision_i) begin
                hit_mask_q <= 1'b0;
            end else if ((state_q == ST_PLAY) && hit) begin
                hit_mask_q <= 1'b1;
            end
        end
    end

    // Output decode from the registered state and counters.
    always_comb begin
        play_en_o   = (state_q == ST_PLAY);
        gameover_o  = (state_q == ST_OVER);
        gamewin_o   = (state_q == ST_WIN);
        respawn_o   = respawn_q;
        state_o     = state_q;
        level_o     = level_q;
        lives_o     = lives_q;
        time_left_o = time_q;
    end

endmodule

// File: tb/tb_frog_game_fsm.sv
// Scoreboard bench for frog_game_fsm: stimulus queues expected output snapshots,
// a negedge monitor pops one whenever the visible outputs change.
module tb_frog_game_fsm;

    localparam int ST_IDLE = 0;
    localparam int ST_PLAY = 1;
    localparam int ST_DEAD = 2;
    localparam int ST_ADV  = 3;
    localparam int ST_WIN  = 4;
    localparam int ST_OVER = 5;

    typedef struct packed {
        logic [2:0] st;
        logic [0:0] lvl;
        logic [1:0] lives;
        logic [1:0] tl;
        logic       resp;
        logic       play;
        logic       over;
        logic       win;
    } snap_t;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       start_i;
    logic       collision_i;
    logic [8:0] frog_y_i;
    logic       play_en_o;
    logic       respawn_o;
    logic [0:0] level_o;
    logic [1:0] lives_o;
    logic [1:0] time_left_o;
    logic [2:0] state_o;
    logic       gameover_o;
    logic       gamewin_o;

    int    checks = 0;
    int    errors = 0;
    snap_t exp_q[$];
    snap_t prev = '1;

    always #5 clk_in = ~clk_in;

    frog_game_fsm #(
        .NUM_LEVELS    (2),
        .START_LIVES   (2),
        .TIME_LIMIT    (3),
        .TICK_DIV      (4),
        .RESPAWN_TICKS (1),
        .Y_W           (9),
        .GOAL_Y        (90)
    ) dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .start_i     (start_i),
        .collision_i (collision_i),
        .frog_y_i    (frog_y_i),
        .play_en_o   (play_en_o),
        .respawn_o   (respawn_o),
        .level_o     (level_o),
        .lives_o     (lives_o),
        .time_left_o (time_left_o),
        .state_o     (state_o),
        .gameover_o  (gameover_o),
        .gamewin_o   (gamewin_o)
    );

    function automatic snap_t mk(int st, int lvl, int lives, int tl, int resp);
        snap_t s;
        s.st    = 3'(st);
        s.lvl   = 1'(lvl);
        s.lives = 2'(lives);
        s.tl    = 2'(tl);
        s.resp  = 1'(resp);
        s.play  = (st == ST_PLAY);
        s.over  = (st == ST_OVER);
        s.win   = (st == ST_WIN);
        return s;
    endfunction

    function automatic snap_t sample();
        snap_t s;
        s.st    = state_o;
        s.lvl   = level_o;
        s.lives = lives_o;
        s.tl    = time_left_o;
        s.resp  = respawn_o;
        s.play  = play_en_o;
        s.over  = gameover_o;
        s.win   = gamewin_o;
        return s;
    endfunction

    task automatic check_snap(input string tag, input snap_t a, input snap_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got st=%0d lvl=%0d lives=%0d tl=%0d resp=%0d play=%0d over=%0d win=%0d want st=%0d lvl=%0d lives=%0d tl=%0d resp=%0d play=%0d over=%0d win=%0d",
                     tag, a.st, a.lvl, a.lives, a.tl, a.resp, a.play, a.over, a.win,
                     e.st, e.lvl, e.lives, e.tl, e.resp, e.play, e.over, e.win);
        end
    endtask

    task automatic push(input int st, input int lvl, input int lives, input int tl, input int resp);
        exp_q.push_back(mk(st, lvl, lives, tl, resp));
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_%s got %0d pending want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_in);
        #1;
        start_i = 1'b0;
    endtask

    task automatic pulse_hit();
        collision_i = 1'b1;
        @(negedge clk_in);
        #1;
        collision_i = 1'b0;
        @(negedge clk_in);
        #1;
    endtask

    // Monitor: every visible output change must match the next queued snapshot.
    always @(negedge clk_in) begin
        snap_t cur;
        cur = sample();
        if (cur !== prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_change got st=%0d lvl=%0d lives=%0d tl=%0d resp=%0d want no change",
                         cur.st, cur.lvl, cur.lives, cur.tl, cur.resp);
            end else begin
                check_snap($sformatf("snap%0d", checks), cur, exp_q.pop_front());
            end
            prev = cur;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in    = 1'b1;
        start_i     = 1'b0;
        collision_i = 1'b0;
        frog_y_i    = 9'd100;
        push(ST_IDLE, 0, 2, 3, 0);
        repeat (2) @(negedge clk_in);
        #1;
        reset_in = 1'b0;
        drain(5, "reset");

        // Timeout death: 3,2,1 then 0 with a life lost, respawn after one tick.
        push(ST_PLAY, 0, 2, 3, 1);
        push(ST_PLAY, 0, 2, 3, 0);
        push(ST_PLAY, 0, 2, 2, 0);
        push(ST_PLAY, 0, 2, 1, 0);
        push(ST_DEAD, 0, 1, 0, 0);
        push(ST_PLAY, 0, 1, 3, 1);
        push(ST_PLAY, 0, 1, 3, 0);
        pulse_start();
        drain(80, "timeout");

        // Collision with frog in goal row on last life: death wins, game over.
        collision_i = 1'b1;
        frog_y_i    = 9'd50;
        push(ST_OVER, 0, 0, 3, 0);
        @(negedge clk_in);
        #1;
        collision_i = 1'b0;
        frog_y_i    = 9'd100;
        drain(10, "over");
        pulse_hit();
        pulse_hit();
        check_snap("over_hold", sample(), mk(ST_OVER, 0, 0, 3, 0));

        push(ST_PLAY, 0, 2, 3, 1);
        push(ST_PLAY, 0, 2, 3, 0);
        pulse_start();
        drain(10, "restart_over");

        // Collision held ten cycles costs one life; then advance to level 1.
        collision_i = 1'b1;
        push(ST_DEAD, 0, 1, 3, 0);
        push(ST_PLAY, 0, 1, 3, 1);
        push(ST_PLAY, 0, 1, 3, 0);
        push(ST_PLAY, 0, 1, 2, 0);
        push(ST_ADV,  0, 1, 2, 0);
        push(ST_PLAY, 1, 2, 3, 1);
        push(ST_PLAY, 1, 2, 3, 0);
        repeat (10) @(negedge clk_in);
        #1;
        collision_i = 1'b0;
        frog_y_i    = 9'd90;
        @(negedge clk_in);
        #1;
        frog_y_i = 9'd100;
        drain(20, "held_advance");

        // Goal on the last level wins; hits in WIN change nothing.
        push(ST_WIN, 1, 2, 3, 0);
        frog_y_i = 9'd90;
        @(negedge clk_in);
        #1;
        frog_y_i = 9'd100;
        drain(10, "win");
        pulse_hit();
        pulse_hit();
        check_snap("win_hold", sample(), mk(ST_WIN, 1, 2, 3, 0));

        push(ST_PLAY, 0, 2, 3, 1);
        push(ST_PLAY, 0, 2, 3, 0);
        pulse_start();
        drain(10, "restart_win");

        // Asynchronous reset in the middle of DEAD.
        collision_i = 1'b1;
        push(ST_DEAD, 0, 1, 3, 0);
        @(negedge clk_in);
        #1;
        collision_i = 1'b0;
        drain(10, "dead");
        #1;
        push(ST_IDLE, 0, 2, 3, 0);
        reset_in = 1'b1;
        #1;
        check_snap("async_reset", sample(), mk(ST_IDLE, 0, 2, 3, 0));
        @(negedge clk_in);
        #1;
        reset_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        drain(10, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
